// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mult_pkg
//  Description : Shared types and Booth select encoding for the sequential
//                radix-4 Booth multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // RV64 multiply flavours as they arrive on the issue interface
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mul_state_e;

  // Booth partial-product select: bit2 = negate, bit1 = 2M, bit0 = 1M
  localparam logic [2:0] c_bsel_zero = 3'b000;
  localparam logic [2:0] c_bsel_p1   = 3'b001;
  localparam logic [2:0] c_bsel_p2   = 3'b010;
  localparam logic [2:0] c_bsel_m1   = 3'b101;
  localparam logic [2:0] c_bsel_m2   = 3'b110;

  // Radix-4 recoding of the triplet {b[2k+1], b[2k], b[2k-1]}
  function automatic logic [2:0] booth_sel(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: return c_bsel_p1;
      3'b011:         return c_bsel_p2;
      3'b100:         return c_bsel_m2;
      3'b101, 3'b110: return c_bsel_m1;
      default:        return c_bsel_zero;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : rca_nbit
//  Description : Plain N-bit ripple-carry adder with carry-in and carry-out.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c,
  output logic [N-1:0] o_s,
  output logic         o_c
);

  logic w_carry;

  // Bit-serial ripple: each stage consumes the carry produced by the one below
  always_comb begin
    o_s     = '0;
    w_carry = i_c;
    for (int k = 0; k < N; k++) begin
      o_s[k]  = i_a[k] ^ i_b[k] ^ w_carry;
      w_carry = (i_a[k] & i_b[k]) | (w_carry & (i_a[k] ^ i_b[k]));
    end
    o_c = w_carry;
  end

endmodule
`default_nettype wire

// File: rtl/mul_booth_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_booth_seq
//  Description : Iterative radix-4 Booth multiplier. One shared ripple adder
//                retires two multiplier bits per cycle; valid/ready on both
//                the request and the result side.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_booth_seq
  import mult_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result
);

  // Operands are widened by two bits so unsigned values recode correctly
  localparam int c_e     = N + 2;
  // Accumulator head-room for +/-2M plus the sign
  localparam int c_w     = N + 4;
  localparam int c_iter  = (N + 2) / 2;
  localparam int c_cnt_w = $clog2(c_iter);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_iter - 1);

  mul_state_e         r_state;
  mul_state_e         w_state_nxt;
  mul_op_e            r_op;
  mul_op_e            w_op;
  logic [c_e-1:0]     r_mcand;
  logic [c_e-1:0]     r_mplr;
  logic               r_bprev;
  logic [c_w-1:0]     r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_valid;
  logic [N-1:0]       r_result;

  logic               w_accept;
  logic               w_step;
  logic               w_finish;
  logic               w_release;
  logic               w_opnd_zero;
  logic [c_e-1:0]     w_a_ext;
  logic [c_e-1:0]     w_b_ext;
  logic [2:0]         w_sel;
  logic [c_w-1:0]     w_m1;
  logic [c_w-1:0]     w_m2;
  logic [c_w-1:0]     w_pp;
  logic [c_w-1:0]     w_addend;
  logic [c_w-1:0]     w_sum;
  logic               w_unused_cout;
  logic [c_w+c_e-1:0] w_shift;

  assign w_op        = mul_op_e'(i_op);
  assign w_opnd_zero = (i_a == '0) || (i_b == '0);

  // Signedness of each operand follows the instruction flavour
  assign w_a_ext = ((w_op == OP_MULH) || (w_op == OP_MULHSU)) ?
                   {{2{i_a[N-1]}}, i_a} : {2'b00, i_a};
  assign w_b_ext = (w_op == OP_MULH) ? {{2{i_b[N-1]}}, i_b} : {2'b00, i_b};

  // Booth recode of the two lowest multiplier bits plus the bit shifted out last
  assign w_sel = booth_sel({r_mplr[1:0], r_bprev});
  assign w_m1  = {{2{r_mcand[c_e-1]}}, r_mcand};
  assign w_m2  = w_m1 << 1;

  // Pick magnitude, then negate through inversion plus adder carry-in
  always_comb begin
    w_pp = '0;
    if (w_sel[0])      w_pp = w_m1;
    else if (w_sel[1]) w_pp = w_m2;
    w_addend = w_sel[2] ? ~w_pp : w_pp;
  end

  rca_nbit #(
    .N (c_w)
  ) u_rca (
    .i_a (r_acc),
    .i_b (w_addend),
    .i_c (w_sel[2]),
    .o_s (w_sum),
    .o_c (w_unused_cout)
  );

  // Arithmetic shift of {acc, multiplier}: low product bits fill the multiplier
  assign w_shift = $signed({w_sum, r_mplr}) >>> 2;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and handshake strobes; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_release   = 1'b0;
    o_ready     = (r_state == IDLE) && i_rst_n;
    if (i_flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid && o_ready) begin
            w_accept    = 1'b1;
            w_state_nxt = w_opnd_zero ? DONE : CALC;
          end
        end
        CALC: begin
          w_step = 1'b1;
          if (r_cnt == c_last) begin
            w_finish    = 1'b1;
            w_state_nxt = DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            w_release   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Operand latch and one Booth iteration per CALC cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op    <= OP_MUL;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_bprev <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_op    <= w_op;
      r_mcand <= w_a_ext;
      r_mplr  <= w_b_ext;
      r_bprev <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_acc   <= w_shift[c_w+c_e-1:c_e];
      r_mplr  <= w_shift[c_e-1:0];
      r_bprev <= r_mplr[1];
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Result register: held steady for the whole DONE stay
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
    end else if (i_flush) begin
      r_valid  <= 1'b0;
    end else if (w_accept && w_opnd_zero) begin
      r_valid  <= 1'b1;
      r_result <= '0;
    end else if (w_finish) begin
      r_valid  <= 1'b1;
      r_result <= (r_op == OP_MUL) ? w_shift[N-1:0] : w_shift[2*N-1:N];
    end else if (w_release) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_result = r_result;

endmodule
`default_nettype wire
